// File: rtl/tank_match_if.sv
// Handshake bundle between the tank match controller and the game/HUD logic.
interface tank_match_if #(
    parameter int N_PLAYERS = 2,
    parameter int HP_W      = 3
);
    logic [N_PLAYERS-1:0]      shot_hit;
    logic [N_PLAYERS-1:0]      heart_pickup;
    logic [N_PLAYERS-1:0]      tank_powerup;
    logic [31:0]               keycode;
    logic [N_PLAYERS*HP_W-1:0] hearts;
    logic [N_PLAYERS-1:0]      alive;
    logic [N_PLAYERS-1:0]      shield_active;
    logic [N_PLAYERS-1:0]      invuln;
    logic                      heart_showup;
    logic                      game_over;
    logic [N_PLAYERS-1:0]      winner;
    logic [1:0]                state;

    modport master (
        output shot_hit, heart_pickup, tank_powerup, keycode,
        input  hearts, alive, shield_active, invuln, heart_showup, game_over, winner, state
    );

    modport slave (
        input  shot_hit, heart_pickup, tank_powerup, keycode,
        output hearts, alive, shield_active, invuln, heart_showup, game_over, winner, state
    );
endinterface

// File: rtl/tank_match_ctrl.sv
// N-player tank match controller: hearts, invulnerability frames, timed heart spawns, restart key.
// The optional one-hit shield is compiled in when TANK_SHIELD_EN is defined.
module tank_match_ctrl #(
    parameter int         N_PLAYERS    = 2,
    parameter int         MAX_HP       = 3,
    parameter int         HP_W         = 3,
    parameter int         IFRAMES      = 30,
    parameter int         HEART_PERIOD = 600,
    parameter logic [7:0] RESTART_KEY  = 8'h0A
) (
    input  logic        frame_clk,
    input  logic        Reset,
    tank_match_if.slave bus
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_OVER = 2'd1
    } state_e;

    localparam int HPX_W = HP_W + 1;
    localparam int IF_W  = $clog2(IFRAMES + 1);
    localparam int SP_W  = $clog2(HEART_PERIOD);
    localparam int CNT_W = $clog2(N_PLAYERS + 1);
    localparam logic [HPX_W-1:0]          MAX_HP_X     = HPX_W'(MAX_HP);
    localparam logic [HP_W-1:0]           MAX_HP_V     = HP_W'(MAX_HP);
    localparam logic [IF_W-1:0]           IFRAMES_V    = IF_W'(IFRAMES);
    localparam logic [SP_W-1:0]           SPAWN_TRIG_V = SP_W'(HEART_PERIOD - 2);
    localparam logic [N_PLAYERS*HP_W-1:0] HEARTS_FULL  = {N_PLAYERS{MAX_HP_V}};

    state_e                    state_q, state_d;
    logic [N_PLAYERS*HP_W-1:0] hearts_q, hearts_d;
    logic [N_PLAYERS-1:0]      alive_q, alive_d;
    logic [N_PLAYERS-1:0]      invuln_q, invuln_d;
    logic [N_PLAYERS-1:0]      winner_q, winner_d;
    logic [N_PLAYERS-1:0]      shot_prev_q, shot_prev_d;
    logic                      key_prev_q, key_prev_d;
    logic [IF_W-1:0]           iframe_q [N_PLAYERS];
    logic [IF_W-1:0]           iframe_d [N_PLAYERS];
    logic [SP_W-1:0]           spawn_q, spawn_d;
    logic                      showup_q, showup_d;
    logic                      game_over_q, game_over_d;

    logic [N_PLAYERS-1:0]      shot_evt_s;
    logic [N_PLAYERS-1:0]      pick_win_s;
    logic [N_PLAYERS-1:0]      shield_cur_s;
    logic                      key_match_s;
    logic                      key_evt_s;
    logic                      play_s;
    logic [N_PLAYERS*HP_W-1:0] tk_hearts_s;
    logic [N_PLAYERS-1:0]      tk_alive_s;
    logic [IF_W-1:0]           tk_iframe_s [N_PLAYERS];
    logic [CNT_W-1:0]          alive_cnt_s;

`ifdef TANK_SHIELD_EN
    logic [N_PLAYERS-1:0] shield_q, shield_d;
    logic [N_PLAYERS-1:0] pow_prev_q, pow_prev_d;
    logic [N_PLAYERS-1:0] pow_evt_s;
    logic [N_PLAYERS-1:0] tk_shield_s;
    assign shield_cur_s      = shield_q;
    assign pow_evt_s         = bus.tank_powerup & ~pow_prev_q;
    assign bus.shield_active = shield_q;
`else
    logic unused_powerup_s;
    assign unused_powerup_s  = ^bus.tank_powerup;
    assign shield_cur_s      = '0;
    assign bus.shield_active = '0;
`endif

    assign key_match_s = (bus.keycode[7:0]   == RESTART_KEY) ||
                         (bus.keycode[15:8]  == RESTART_KEY) ||
                         (bus.keycode[23:16] == RESTART_KEY) ||
                         (bus.keycode[31:24] == RESTART_KEY);
    assign key_evt_s   = key_match_s & ~key_prev_q;
    assign shot_evt_s  = bus.shot_hit & ~shot_prev_q;
    assign play_s      = (state_q == ST_PLAY);

    // Lowest-index alive tank touching the visible heart takes it.
    always_comb begin
        logic taken_v;
        taken_v    = 1'b0;
        pick_win_s = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!taken_v && play_s && showup_q && alive_q[i] && bus.heart_pickup[i]) begin
                pick_win_s[i] = 1'b1;
                taken_v       = 1'b1;
            end else begin
                pick_win_s[i] = 1'b0;
            end
        end
    end

    // Per-tank damage, heal, shield and iframe update for one frame.
    always_comb begin
        logic             hit_v;
        logic             dmg_v;
        logic [HPX_W-1:0] sum_v;
        tk_hearts_s = hearts_q;
        tk_alive_s  = alive_q;
        tk_iframe_s = iframe_q;
`ifdef TANK_SHIELD_EN
        tk_shield_s = shield_q;
`endif
        for (int i = 0; i < N_PLAYERS; i++) begin
            hit_v = 1'b0;
            dmg_v = 1'b0;
            sum_v = '0;
            tk_iframe_s[i] = (iframe_q[i] != '0) ? (iframe_q[i] - IF_W'(1)) : '0;
            if (play_s && alive_q[i]) begin
                hit_v = shot_evt_s[i] && (iframe_q[i] == '0);
                dmg_v = hit_v && !shield_cur_s[i];
                // Heal saturates at the ceiling before a same-frame hit is taken off.
                sum_v = {1'b0, hearts_q[i*HP_W +: HP_W]} + {{HP_W{1'b0}}, pick_win_s[i]};
                sum_v = (sum_v > MAX_HP_X) ? MAX_HP_X : sum_v;
                sum_v = sum_v - {{HP_W{1'b0}}, dmg_v};
                tk_hearts_s[i*HP_W +: HP_W] = sum_v[HP_W-1:0];
                tk_alive_s[i] = (sum_v != '0);
                tk_iframe_s[i] = hit_v ? IFRAMES_V : tk_iframe_s[i];
`ifdef TANK_SHIELD_EN
                tk_shield_s[i] = (shield_q[i] & ~hit_v) | pow_evt_s[i];
`endif
            end else begin
                tk_alive_s[i] = alive_q[i];
            end
        end
    end

    // Survivor count after this frame's damage.
    always_comb begin
        alive_cnt_s = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            alive_cnt_s = alive_cnt_s + CNT_W'(tk_alive_s[i]);
        end
    end

    // Next state: the match ends once at most one tank survives; a fresh key press restarts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY: state_d = (alive_cnt_s <= CNT_W'(1)) ? ST_OVER : ST_PLAY;
            ST_OVER: state_d = key_evt_s ? ST_PLAY : ST_OVER;
            default: state_d = ST_PLAY;
        endcase
    end

    // Next values for every registered output, counter and edge-detect history.
    always_comb begin
        hearts_d    = hearts_q;
        alive_d     = alive_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        showup_d    = showup_q;
        spawn_d     = spawn_q;
        shot_prev_d = bus.shot_hit;
        key_prev_d  = key_match_s;
        iframe_d    = tk_iframe_s;
`ifdef TANK_SHIELD_EN
        shield_d    = shield_q;
        pow_prev_d  = bus.tank_powerup;
`endif
        if (state_q == ST_OVER) begin
            if (key_evt_s) begin
                hearts_d    = HEARTS_FULL;
                alive_d     = '1;
                winner_d    = '0;
                game_over_d = 1'b0;
                showup_d    = 1'b0;
                spawn_d     = '0;
                shot_prev_d = '0;
                key_prev_d  = 1'b0;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    iframe_d[i] = '0;
                end
`ifdef TANK_SHIELD_EN
                shield_d    = '0;
                pow_prev_d  = '0;
`endif
            end else begin
                hearts_d = hearts_q;
            end
        end else begin
            hearts_d = tk_hearts_s;
            alive_d  = tk_alive_s;
`ifdef TANK_SHIELD_EN
            shield_d = tk_shield_s;
`endif
            if (showup_q) begin
                showup_d = ~(|pick_win_s);
            end else if (spawn_q == SPAWN_TRIG_V) begin
                showup_d = 1'b1;
                spawn_d  = '0;
            end else begin
                spawn_d  = spawn_q + SP_W'(1);
            end
            if (state_d == ST_OVER) begin
                game_over_d = 1'b1;
                winner_d    = tk_alive_s;
                showup_d    = 1'b0;
            end else begin
                game_over_d = 1'b0;
                winner_d    = '0;
            end
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            invuln_d[i] = (iframe_d[i] != '0);
        end
    end

    // Match state register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, counters and edge-detect history.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            hearts_q    <= HEARTS_FULL;
            alive_q     <= '1;
            invuln_q    <= '0;
            winner_q    <= '0;
            shot_prev_q <= '0;
            key_prev_q  <= 1'b0;
            spawn_q     <= '0;
            showup_q    <= 1'b0;
            game_over_q <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                iframe_q[i] <= '0;
            end
`ifdef TANK_SHIELD_EN
            shield_q    <= '0;
            pow_prev_q  <= '0;
`endif
        end else begin
            hearts_q    <= hearts_d;
            alive_q     <= alive_d;
            invuln_q    <= invuln_d;
            winner_q    <= winner_d;
            shot_prev_q <= shot_prev_d;
            key_prev_q  <= key_prev_d;
            spawn_q     <= spawn_d;
            showup_q    <= showup_d;
            game_over_q <= game_over_d;
            for (int i = 0; i < N_PLAYERS; i++) begin
                iframe_q[i] <= iframe_d[i];
            end
`ifdef TANK_SHIELD_EN
            shield_q    <= shield_d;
            pow_prev_q  <= pow_prev_d;
`endif
        end
    end

    assign bus.hearts       = hearts_q;
    assign bus.alive        = alive_q;
    assign bus.invuln       = invuln_q;
    assign bus.heart_showup = showup_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;
    assign bus.state        = state_q;

endmodule
